// File: rtl/rf_pkg.sv
// Shared defaults and sizing helper for the scoreboarded register file.
package rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NRD_DEF    = 2;

   // Number of architectural registers addressed by an addr_w-bit index.
   function automatic int nreg(input int addr_w);
      return 2 ** addr_w;
   endfunction

   localparam int NREG_DEF = nreg(ADDR_W_DEF);

endpackage

// File: rtl/rf_read_port.sv
// One combinational read path: zero-register check, writeback bypass, storage mux, busy flag.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int BYPASS = 1
)(
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] mem_i [NREG],
   input  logic [NREG-1:0]   pend_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_busy_o
);

   logic addr_zero;
   logic byp_hit;

   assign addr_zero = (rd_addr_i == '0);
   assign byp_hit   = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i) && !addr_zero;

   // Select forwarded writeback data over stored state; r0 always reads as an idle zero.
   always_comb begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
      if (addr_zero) begin
         rd_data_o = '0;
         rd_busy_o = 1'b0;
      end else if (byp_hit) begin
         rd_data_o = wr_data_i;
         rd_busy_o = 1'b0;
      end else begin
         rd_data_o = mem_i[rd_addr_i];
         rd_busy_o = pend_i[rd_addr_i];
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with writeback bypass and a single-bit pending-write scoreboard.
module regfile_sb
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = NRD_DEF,
   parameter int BYPASS = 1
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NRD*ADDR_W-1:0]   rd_addr,
   output logic [NRD*DATA_W-1:0]   rd_data,
   output logic [NRD-1:0]          rd_busy,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   input  logic                    flush,
   output logic [nreg(ADDR_W)-1:0] busy_vec
);

   localparam int NREG = nreg(ADDR_W);

   logic [DATA_W-1:0] mem_q [1:NREG-1];
   logic [DATA_W-1:0] mem_view [NREG];
   logic [NREG-1:0]   pend_q;
   logic [NREG-1:0]   pend_d;
   logic              wr_hit;
   logic              iss_hit;

   assign wr_hit  = wr_en  && (wr_addr  != '0);
   assign iss_hit = iss_en && (iss_addr != '0);

   // Scoreboard next state: writeback clears, issue sets (new producer wins), flush clears all.
   always_comb begin
      pend_d = pend_q;
      if (wr_hit)
         pend_d[wr_addr] = 1'b0;
      if (iss_hit)
         pend_d[iss_addr] = 1'b1;
      if (flush)
         pend_d = '0;
      pend_d[0] = 1'b0;
   end

   // Pending bits, cleared asynchronously on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pend_q <= '0;
      else
         pend_q <= pend_d;
   end

   // Register storage for r1..r(NREG-1); writes land even during a flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 1; i < NREG; i++)
            mem_q[i] <= '0;
      end else if (wr_hit) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Full-range view for the read muxes, with r0 tied to zero.
   always_comb begin
      mem_view[0] = '0;
      for (int unsigned i = 1; i < NREG; i++)
         mem_view[i] = mem_q[i];
   end

   assign busy_vec = pend_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      rf_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NREG   (NREG),
         .BYPASS (BYPASS)
      ) u_port (
         .rd_addr_i (rd_addr[k*ADDR_W +: ADDR_W]),
         .wr_en_i   (wr_en),
         .wr_addr_i (wr_addr),
         .wr_data_i (wr_data),
         .mem_i     (mem_view),
         .pend_i    (pend_q),
         .rd_data_o (rd_data[k*DATA_W +: DATA_W]),
         .rd_busy_o (rd_busy[k])
      );
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with a write-to-read bypass and a per-register pending-write scoreboard, for the pipelined CPU datapath. Decode reads operands and marks destination registers pending at issue. Writeback clears the pending bit and stores the result. Register 0 is hardwired to zero and is never pending.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREG = 2**ADDR_W registers
- NRD, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = no forwarding
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NRD  1 = addressed register has an outstanding write (after bypass)
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- iss_en  in  1  issue strobe: mark iss_addr pending
- iss_addr  in  ADDR_W  issued destination register
- flush  in  1  clear all pending bits (pipeline squash)
- busy_vec  out  NREG  current pending bits, bit 0 constantly 0

## Operation
- Storage: registers 1..NREG-1 of DATA_W bits. Register 0 is not stored.
- Read of address 0: rd_data = 0, rd_busy = 0, regardless of any write or issue.
- Read of address a != 0, no bypass hit: rd_data = mem[a], rd_busy = pend[a].
- Bypass hit (BYPASS=1, wr_en, wr_addr == rd_addr != 0): rd_data = wr_data, rd_busy = 0. This applies independently on every port.
- With BYPASS=0, a same-cycle write is not visible until the next cycle. rd_busy then reflects pend[a] before the edge.
- Write: wr_en && wr_addr != 0 -> mem[wr_addr] <= wr_data and pend[wr_addr] <= 0 at the edge.
- Issue: iss_en && iss_addr != 0 -> pend[iss_addr] <= 1.
- Issue and write to the same address in the same cycle: data is written, and pend ends at 1 (a new producer wins).
- Flush: all pend <= 0. Flush overrides a same-cycle issue. A same-cycle write still updates mem.
- Issue to an already-pending register: it stays 1. Single-bit scoreboard; there is no count of in-flight producers.
- Write to a non-pending register: data is stored, pend stays 0. This is legal.

## Timing
- Reads have zero latency (combinational from rd_addr, wr_*, and state).
- Writes, issue, and flush take effect at the rising clk edge. They are visible to non-bypassed reads in the next cycle.
- While reset is 0: mem = 0, pend = 0, busy_vec = 0. rd_data for any address = 0, except a bypass hit still forwards wr_data. rd_busy = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first edge after deassertion performs normal updates.
- No handshake back-pressure: every strobe is accepted in the cycle it is presented.

## Structure
- Package rf_pkg: default DATA_W/ADDR_W/NRD constants and a localparam NREG function (2**ADDR_W).
- Sub-module rf_read_port: one combinational read path (zero check, bypass compare, mux, busy). It is instantiated NRD times via generate.
- Top holds the storage array, the pend vector, and the write/issue/flush logic.

## Test plan
- Reset: drive reset=0 mid-traffic; rd_data on all ports = 0 and busy_vec = 0 immediately. After release, reading r5 returns 0.
- Write/read: write r3=0xDEADBEEF. Next cycle, port0 rd_addr=3 -> 0xDEADBEEF. Write r0=0x1234, then read r0 -> 0, busy 0.
- Bypass: BYPASS=1, wr r7=0xA5A5A5A5 with rd_addr0=7 same cycle -> rd_data0=0xA5A5A5A5, rd_busy0=0. BYPASS=0 build: same stimulus -> old r7 value.
- Scoreboard: issue r9 -> next cycle busy_vec[9]=1 and rd_busy on r9 = 1. Write r9=0x55 -> next cycle busy_vec[9]=0 and rd_data=0x55.
- Simultaneous: issue r4 and write r4=0x11 same cycle -> mem[r4]=0x11, busy_vec[4]=1. Issue r0 -> busy_vec[0] stays 0.
- Flush: pend r2,r6 set; flush with iss r8 and wr r2=0x77 same cycle -> busy_vec all 0 and r2 reads 0x77.
